// File: rtl/nec_ir_decoder.sv
// nec_ir_decoder: measures NEC IR pulse widths, validates frames and publishes command/repeat strobes.
// Each timebase tick spans 2**TICK_SHIFT us; all microsecond thresholds are scaled to match.
module nec_ir_decoder #(
    parameter int CLK_DIV          = 25,
    parameter bit CHECK_ADDR_INV   = 1,
    parameter int REPEAT_WINDOW_US = 120000,
    parameter int TICK_SHIFT       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inf_in,
    output logic [7:0] data_inf,
    output logic [7:0] addr_inf,
    output logic       press_flag,
    output logic       repeat_en,
    output logic       frame_err
);
    localparam logic [13:0] LL_MIN  = 14'(8500 >> TICK_SHIFT);
    localparam logic [13:0] LL_MAX  = 14'(9500 >> TICK_SHIFT);
    localparam logic [13:0] LHD_MIN = 14'(4000 >> TICK_SHIFT);
    localparam logic [13:0] LHD_MAX = 14'(5000 >> TICK_SHIFT);
    localparam logic [13:0] LHR_MIN = 14'(2000 >> TICK_SHIFT);
    localparam logic [13:0] LHR_MAX = 14'(2500 >> TICK_SHIFT);
    localparam logic [13:0] B_MIN   = 14'(400 >> TICK_SHIFT);
    localparam logic [13:0] B_MAX   = 14'(700 >> TICK_SHIFT);
    localparam logic [13:0] H1_MIN  = 14'(1500 >> TICK_SHIFT);
    localparam logic [13:0] H1_MAX  = 14'(1900 >> TICK_SHIFT);
    localparam logic [13:0] TOUT    = 14'(10000 >> TICK_SHIFT);
    localparam logic [16:0] RWIN    = 17'(REPEAT_WINDOW_US >> TICK_SHIFT);

    typedef enum logic [2:0] {IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, STOP_LOW, DONE} state_t;

    state_t      state;
    logic        s1, s2, s3;
    logic [15:0] pre;
    logic [13:0] us;
    logic [16:0] rep_cnt;
    logic [31:0] sr;
    logic [5:0]  bit_cnt;
    logic        is_rep, rep_ok;
    logic        fall, rise, tick, timeout;
    logic        w_ll, w_lhd, w_lhr, w_b, w_h1, frame_ok;

    function automatic logic in_win(input logic [13:0] w, input logic [13:0] lo, input logic [13:0] hi);
        return w >= lo && w <= hi;
    endfunction

    assign fall     = s3 & ~s2;
    assign rise     = ~s3 & s2;
    assign tick     = pre == 16'(CLK_DIV - 1);
    assign timeout  = state != IDLE && state != DONE && us >= TOUT;
    assign w_ll     = in_win(us, LL_MIN, LL_MAX);
    assign w_lhd    = in_win(us, LHD_MIN, LHD_MAX);
    assign w_lhr    = in_win(us, LHR_MIN, LHR_MAX);
    assign w_b      = in_win(us, B_MIN, B_MAX);
    assign w_h1     = in_win(us, H1_MIN, H1_MAX);
    // sr holds {cmd_inv, cmd, addr_inv, addr} once all 32 bits are in
    assign frame_ok = sr[23:16] == ~sr[31:24] && (!CHECK_ADDR_INV || sr[7:0] == ~sr[15:8]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            {s1, s2, s3} <= 3'b111;
            pre        <= '0;
            us         <= '0;
            rep_cnt    <= '0;
            sr         <= '0;
            bit_cnt    <= '0;
            is_rep     <= 1'b0;
            rep_ok     <= 1'b0;
            data_inf   <= '0;
            addr_inf   <= '0;
            press_flag <= 1'b0;
            repeat_en  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            {s1, s2, s3} <= {inf_in, s1, s2};
            press_flag <= 1'b0;
            repeat_en  <= 1'b0;
            frame_err  <= 1'b0;
            if (fall || rise) begin
                pre <= '0;
                us  <= '0;
            end else begin
                pre <= tick ? '0 : pre + 16'd1;
                if (tick && us != 14'h3fff) us <= us + 14'd1;
            end
            if (tick && rep_cnt != '1) rep_cnt <= rep_cnt + 17'd1;
            if (rep_cnt >= RWIN) rep_ok <= 1'b0;
            if (timeout) begin
                state     <= IDLE;
                frame_err <= state != LEAD_LOW;
            end else begin
                case (state)
                    IDLE: if (fall) state <= LEAD_LOW;
                    LEAD_LOW: if (rise) state <= w_ll ? LEAD_HIGH : IDLE;
                    LEAD_HIGH: if (fall) begin
                        bit_cnt   <= '0;
                        is_rep    <= !w_lhd && w_lhr;
                        state     <= w_lhd ? BIT_LOW : w_lhr ? STOP_LOW : IDLE;
                        frame_err <= !w_lhd && !w_lhr;
                    end
                    BIT_LOW: if (rise) begin
                        state     <= w_b ? BIT_HIGH : IDLE;
                        frame_err <= !w_b;
                    end
                    BIT_HIGH: if (fall) begin
                        if (w_b || w_h1) begin
                            sr      <= {w_h1, sr[31:1]};
                            bit_cnt <= bit_cnt + 6'd1;
                            state   <= bit_cnt == 6'd31 ? STOP_LOW : BIT_LOW;
                        end else begin
                            state     <= IDLE;
                            frame_err <= 1'b1;
                        end
                    end
                    STOP_LOW: if (rise) begin
                        state     <= w_b ? DONE : IDLE;
                        frame_err <= !w_b;
                    end
                    DONE: begin
                        state <= IDLE;
                        if (is_rep) begin
                            if (rep_ok) begin
                                repeat_en <= 1'b1;
                                rep_cnt   <= '0;
                            end
                        end else if (frame_ok) begin
                            data_inf   <= sr[23:16];
                            addr_inf   <= sr[7:0];
                            press_flag <= 1'b1;
                            rep_ok     <= 1'b1;
                            rep_cnt    <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nec_ir_decoder.sv
// tb_nec_ir_decoder: drives NEC waveforms with a 16 us tick and scores strobes against a queue of expected events.
module tb_nec_ir_decoder;
    localparam int RW = 120000 >> 4;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic [7:0] addr;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inf_in = 1'b1;
    logic [7:0] data_inf, addr_inf;
    logic       press_flag, repeat_en, frame_err;

    ev_t        q[$];
    ev_t        e;
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         last_pub = -1000000;
    bit         m_rep_ok = 1'b0;
    logic [7:0] m_data = '0;
    logic [7:0] m_addr = '0;

    nec_ir_decoder #(
        .CLK_DIV(1),
        .CHECK_ADDR_INV(1),
        .REPEAT_WINDOW_US(120000),
        .TICK_SHIFT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .inf_in(inf_in),
        .data_inf(data_inf),
        .addr_inf(addr_inf),
        .press_flag(press_flag),
        .repeat_en(repeat_en),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sc(input int n, input int pct);
        return n * pct / 100;
    endfunction

    task automatic hold(input logic lvl, input int n);
        inf_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits, input int pct);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, sc(35, pct));
            hold(1'b1, sc(w[i] ? 106 : 35, pct));
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] ai, input logic [7:0] c,
                              input logic [7:0] ci, input int pct);
        logic [31:0] w;
        bit ok;
        w = {ci, c, ai, a};
        ok = c == ~ci && a == ~ai;
        if (ok) begin
            q.push_back(ev_t'{0, c, a});
            m_data = c;
            m_addr = a;
        end else begin
            q.push_back(ev_t'{2, m_data, m_addr});
        end
        hold(1'b0, sc(563, pct));
        hold(1'b1, sc(281, pct));
        send_bits(w, 32, pct);
        hold(1'b0, sc(35, pct));
        if (ok) begin
            m_rep_ok = 1'b1;
            last_pub = cyc;
        end
        hold(1'b1, 200);
    endtask

    task automatic send_repeat(input int gap);
        hold(1'b1, gap);
        hold(1'b0, 563);
        hold(1'b1, 140);
        hold(1'b0, 35);
        if (cyc - last_pub >= RW) m_rep_ok = 1'b0;
        if (m_rep_ok) begin
            q.push_back(ev_t'{1, m_data, m_addr});
            last_pub = cyc;
        end
        hold(1'b1, 200);
    endtask

    always @(negedge clk) begin
        if (rst_n && (press_flag || repeat_en || frame_err)) begin
            if (q.size() == 0) begin
                check("spurious_strobe", {29'd0, press_flag, repeat_en, frame_err}, 32'd0);
            end else begin
                e = q.pop_front();
                check("strobe_onehot", $countones({press_flag, repeat_en, frame_err}), 32'd1);
                check("strobe_kind", press_flag ? 32'd0 : repeat_en ? 32'd1 : 32'd2, e.kind);
                check("data_inf", {24'd0, data_inf}, {24'd0, e.data});
                check("addr_inf", {24'd0, addr_inf}, {24'd0, e.addr});
            end
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        check("rst_data", {24'd0, data_inf}, 32'd0);
        check("rst_addr", {24'd0, addr_inf}, 32'd0);
        check("rst_press", {31'd0, press_flag}, 32'd0);
        check("rst_repeat", {31'd0, repeat_en}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        hold(1'b1, 100);

        send_frame(8'h00, 8'hFF, 8'h15, 8'hEA, 100);
        send_repeat(2500);
        send_repeat(12500);

        send_frame(8'h00, 8'hFF, 8'h0C, 8'hF2, 100);
        send_frame(8'h10, 8'h10, 8'h22, 8'hDD, 100);

        hold(1'b0, 437);
        hold(1'b1, 300);
        send_frame(8'h04, 8'hFB, 8'h3A, 8'hC5, 100);

        q.push_back(ev_t'{2, m_data, m_addr});
        hold(1'b0, 563);
        hold(1'b1, 281);
        send_bits(32'h5A5A_A5A5, 10, 100);
        hold(1'b0, 35);
        hold(1'b1, 750);
        send_frame(8'h00, 8'hFF, 8'h5E, 8'hA1, 100);

        hold(1'b0, 563);
        hold(1'b1, 281);
        send_bits(32'h33CC_00FF, 19, 100);
        hold(1'b0, 20);
        rst_n = 1'b0;
        #1;
        check("midrst_data", {24'd0, data_inf}, 32'd0);
        check("midrst_addr", {24'd0, addr_inf}, 32'd0);
        check("midrst_strobes", {29'd0, press_flag, repeat_en, frame_err}, 32'd0);
        m_data = '0;
        m_addr = '0;
        m_rep_ok = 1'b0;
        repeat (3) @(negedge clk);
        inf_in = 1'b1;
        rst_n = 1'b1;
        hold(1'b1, 200);
        send_frame(8'h00, 8'hFF, 8'h07, 8'hF8, 100);

        send_frame(8'h01, 8'hFE, 8'h33, 8'hCC, 105);
        send_frame(8'h80, 8'h7F, 8'hC1, 8'h3E, 95);

        hold(1'b1, 50);
        check("queue_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
